// File: rtl/sram_access_arbiter_pkg.sv
// Shared encodings for the external SRAM access arbiter:
// FSM states, grant ids, address width and the round-robin pick.
package sram_access_arbiter_pkg;

  localparam int SRAM_AW = 19;
  localparam int CNT_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_DONE
  } state_t;

  typedef enum logic {
    GRANT_A,
    GRANT_B
  } grant_t;

  // On a tie the port that was not served last wins.
  function automatic grant_t pick_grant(
    input logic   a_req,
    input logic   b_req,
    input grant_t last
  );
    grant_t g;
    if (a_req && b_req) begin
      g = (last == GRANT_A) ? GRANT_B : GRANT_A;
    end else if (a_req) begin
      g = GRANT_A;
    end else begin
      g = GRANT_B;
    end
    return g;
  endfunction

endpackage

// File: rtl/sram_access_arbiter.sv
// Two-port round-robin sequencer for the 512Kx8 SRAM (setup/strobe/hold).
// Ports: a_*/b_* requesters, sram_* pin-side bus (tristate built above), busy.
module sram_access_arbiter
  import sram_access_arbiter_pkg::*;
#(
  parameter int AW          = SRAM_AW,
  parameter int WAIT_STATES = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [7:0]    a_wdata,
  output logic          a_ack,
  output logic [7:0]    a_rdata,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [7:0]    b_wdata,
  output logic          b_ack,
  output logic [7:0]    b_rdata,
  output logic [AW-1:0] sram_addr,
  output logic [7:0]    sram_data_out,
  output logic          sram_data_oe,
  input  logic [7:0]    sram_data_in,
  output logic          sram_we_n,
  output logic          busy
);

  localparam logic [CNT_W-1:0] CNT_LOAD =
    CNT_W'(WAIT_STATES - 1);

  state_t            state_q, state_d;
  grant_t            grant_q, grant_d;
  grant_t            last_q, last_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;

  logic [AW-1:0]     addr_d;
  logic [7:0]        dout_d;
  logic              oe_d;
  logic              we_n_d;
  logic              a_ack_d, b_ack_d;
  logic [7:0]        a_rdata_d, b_rdata_d;
  logic              busy_d;

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    addr_d    = sram_addr;
    dout_d    = sram_data_out;
    oe_d      = sram_data_oe;
    we_n_d    = 1'b1;
    a_ack_d   = 1'b0;
    b_ack_d   = 1'b0;
    a_rdata_d = a_rdata;
    b_rdata_d = b_rdata;

    unique case (state_q)
      ST_IDLE: begin
        oe_d = 1'b0;
        if (a_req || b_req) begin
          grant_d = pick_grant(a_req, b_req, last_q);
          last_d  = grant_d;
          state_d = ST_SETUP;
          if (grant_d == GRANT_A) begin
            addr_d = a_addr;
            we_d   = a_we;
            if (a_we) dout_d = a_wdata;
          end else begin
            addr_d = b_addr;
            we_d   = b_we;
            if (b_we) dout_d = b_wdata;
          end
          // Data is driven from SETUP so it is stable before the strobe.
          oe_d = we_d;
        end
      end
      ST_SETUP: begin
        cnt_d   = CNT_LOAD;
        we_n_d  = ~we_q;
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (cnt_q == '0) begin
          state_d = ST_DONE;
          if (!we_q) begin
            if (grant_q == GRANT_A) a_rdata_d = sram_data_in;
            else                    b_rdata_d = sram_data_in;
          end
          a_ack_d = (grant_q == GRANT_A);
          b_ack_d = (grant_q == GRANT_B);
        end else begin
          cnt_d  = cnt_q - 1'b1;
          we_n_d = ~we_q;
        end
      end
      ST_DONE: begin
        // Strobe already released; addr/data held one more cycle.
        oe_d    = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      grant_q       <= GRANT_A;
      last_q        <= GRANT_B;
      cnt_q         <= '0;
      we_q          <= 1'b0;
      sram_addr     <= '0;
      sram_data_out <= '0;
      sram_data_oe  <= 1'b0;
      sram_we_n     <= 1'b1;
      a_ack         <= 1'b0;
      b_ack         <= 1'b0;
      a_rdata       <= '0;
      b_rdata       <= '0;
      busy          <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      last_q        <= last_d;
      cnt_q         <= cnt_d;
      we_q          <= we_d;
      sram_addr     <= addr_d;
      sram_data_out <= dout_d;
      sram_data_oe  <= oe_d;
      sram_we_n     <= we_n_d;
      a_ack         <= a_ack_d;
      b_ack         <= b_ack_d;
      a_rdata       <= a_rdata_d;
      b_rdata       <= b_rdata_d;
      busy          <= busy_d;
    end
  end

endmodule

// File: tb/tb_sram_access_arbiter.sv
// Bench for sram_access_arbiter: directed scenarios plus randomized
// rounds against a transaction-level model with an SRAM memory model.
`timescale 1ns/1ps
module tb_sram_access_arbiter;

  localparam int AW = 19;
  localparam int WS = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          a_req = 1'b0, a_we = 1'b0;
  logic [AW-1:0] a_addr = '0;
  logic [7:0]    a_wdata = '0;
  logic          b_req = 1'b0, b_we = 1'b0;
  logic [AW-1:0] b_addr = '0;
  logic [7:0]    b_wdata = '0;
  logic          a_ack, b_ack, sram_data_oe, sram_we_n, busy;
  logic [7:0]    a_rdata, b_rdata, sram_data_out;
  logic [7:0]    sram_data_in = '0;
  logic [AW-1:0] sram_addr;

  sram_access_arbiter #(.AW(AW), .WAIT_STATES(WS)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rdata(b_rdata),
    .sram_addr(sram_addr), .sram_data_out(sram_data_out),
    .sram_data_oe(sram_data_oe), .sram_data_in(sram_data_in),
    .sram_we_n(sram_we_n), .busy(busy)
  );

  // Extra instances for the wait-state extremes, driven on port A only.
  logic          r1_req = 1'b0, r15_req = 1'b0;
  logic [AW-1:0] w_addr = 19'h00042;
  logic [7:0]    w_wdata = 8'h99;
  logic          x1_aack, x1_back, x1_oe, x1_wen, x1_busy;
  logic [7:0]    x1_ard, x1_brd, x1_dout;
  logic [AW-1:0] x1_addr;
  logic          x15_aack, x15_back, x15_oe, x15_wen, x15_busy;
  logic [7:0]    x15_ard, x15_brd, x15_dout;
  logic [AW-1:0] x15_addr;

  sram_access_arbiter #(.AW(AW), .WAIT_STATES(1)) u_ws1 (
    .clk(clk), .rst(rst),
    .a_req(r1_req), .a_we(1'b1), .a_addr(w_addr), .a_wdata(w_wdata),
    .a_ack(x1_aack), .a_rdata(x1_ard),
    .b_req(1'b0), .b_we(1'b0), .b_addr('0), .b_wdata(8'h00),
    .b_ack(x1_back), .b_rdata(x1_brd),
    .sram_addr(x1_addr), .sram_data_out(x1_dout),
    .sram_data_oe(x1_oe), .sram_data_in(8'h00),
    .sram_we_n(x1_wen), .busy(x1_busy)
  );

  sram_access_arbiter #(.AW(AW), .WAIT_STATES(15)) u_ws15 (
    .clk(clk), .rst(rst),
    .a_req(r15_req), .a_we(1'b1), .a_addr(w_addr), .a_wdata(w_wdata),
    .a_ack(x15_aack), .a_rdata(x15_ard),
    .b_req(1'b0), .b_we(1'b0), .b_addr('0), .b_wdata(8'h00),
    .b_ack(x15_back), .b_rdata(x15_brd),
    .sram_addr(x15_addr), .sram_data_out(x15_dout),
    .sram_data_oe(x15_oe), .sram_data_in(8'h00),
    .sram_we_n(x15_wen), .busy(x15_busy)
  );

  int n_pass = 0;
  int n_total = 0;

  // sram_mem: what the SRAM model holds. ref_mem: what the bench expects.
  logic [7:0] sram_mem [int];
  logic [7:0] ref_mem [int];
  bit         last_b = 1'b1;
  logic [7:0] exp_ard = '0, exp_brd = '0;

  function automatic logic [7:0] pat(input logic [AW-1:0] ad);
    return ad[7:0] ^ ad[15:8] ^ {5'd0, ad[18:16]} ^ 8'h5A;
  endfunction

  function automatic logic [7:0] sram_rd(input logic [AW-1:0] ad);
    if (sram_mem.exists(int'(ad))) return sram_mem[int'(ad)];
    return pat(ad);
  endfunction

  function automatic logic [7:0] ref_rd(input logic [AW-1:0] ad);
    if (ref_mem.exists(int'(ad))) return ref_mem[int'(ad)];
    return pat(ad);
  endfunction

  always @(posedge clk)
    if (!sram_we_n && sram_data_oe)
      sram_mem[int'(sram_addr)] = sram_data_out;

  always @(negedge clk) sram_data_in = sram_rd(sram_addr);

  always @(negedge clk) begin
    if (!rst) begin
      n_total++;
      if (!sram_we_n && !(sram_data_oe && busy))
        $display("FAIL inv_strobe: we_n=%b oe=%b busy=%b",
                 sram_we_n, sram_data_oe, busy);
      else n_pass++;
      n_total++;
      if (a_ack && b_ack)
        $display("FAIL inv_ack_onehot: a_ack=%b b_ack=%b", a_ack, b_ack);
      else n_pass++;
    end
  end

  logic [63:0]   cap_wen, cap_oe, cap_aack, cap_back;
  logic [AW-1:0] cap_addr [64];
  logic [7:0]    cap_ard [64];
  logic [7:0]    cap_brd [64];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Records ncyc cycles from the first negedge; drops a port's req in
  // the cycle after its a_n-th / b_n-th ack.
  task automatic capture(input int ncyc, input int a_n, input int b_n);
    int   ac, bc;
    logic drop_a, drop_b;
    ac = 0;
    bc = 0;
    cap_wen = '0; cap_oe = '0; cap_aack = '0; cap_back = '0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      cap_wen[c]  = sram_we_n;
      cap_oe[c]   = sram_data_oe;
      cap_aack[c] = a_ack;
      cap_back[c] = b_ack;
      cap_addr[c] = sram_addr;
      cap_ard[c]  = a_rdata;
      cap_brd[c]  = b_rdata;
      drop_a = 1'b0;
      drop_b = 1'b0;
      if (a_ack) begin ac++; drop_a = (ac == a_n); end
      if (b_ack) begin bc++; drop_b = (bc == b_n); end
      if (drop_a || drop_b) begin
        tick();
        if (drop_a) a_req = 1'b0;
        if (drop_b) b_req = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    bit seen;
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_total++;
    if ({sram_we_n, sram_data_oe, busy, a_ack, b_ack} !== 5'b10000)
      $display("FAIL reset_ctrl: got %b want 10000",
               {sram_we_n, sram_data_oe, busy, a_ack, b_ack});
    else n_pass++;
    n_total++;
    if ({sram_addr, sram_data_out, a_rdata, b_rdata} !== '0)
      $display("FAIL reset_data: addr=%h dout=%h ard=%h brd=%h",
               sram_addr, sram_data_out, a_rdata, b_rdata);
    else n_pass++;
    tick();
    rst = 1'b0;
    tick();
    a_req = 1'b1; a_we = 1'b1; a_addr = 19'h00100; a_wdata = 8'h77;
    for (int i = 0; i < 10 && sram_we_n !== 1'b0; i++) @(negedge clk);
    n_total++;
    if (sram_we_n !== 1'b0)
      $display("FAIL reset_strobe_timeout: we_n=%b want 0", sram_we_n);
    else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_total++;
    if ({sram_we_n, sram_data_oe, a_ack, b_ack, busy} !== 5'b10000)
      $display("FAIL reset_midwrite: got %b want 10000",
               {sram_we_n, sram_data_oe, a_ack, b_ack, busy});
    else n_pass++;
    a_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    last_b = 1'b1;
    exp_ard = '0;
    exp_brd = '0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (a_ack || b_ack || busy) seen = 1'b1;
    end
    n_total++;
    if (seen !== 1'b0)
      $display("FAIL reset_lost_access: activity=%b want 0", seen);
    else n_pass++;
  endtask

  task automatic test_single_write();
    tick();
    a_req = 1'b1; a_we = 1'b1; a_addr = 19'h12345; a_wdata = 8'hA5;
    capture(6, 1, 0);
    n_total++;
    if (cap_addr[1] !== 19'h12345)
      $display("FAIL wr_setup_addr: got %h want 12345", cap_addr[1]);
    else n_pass++;
    n_total++;
    if (cap_wen[5:0] !== 6'b110011)
      $display("FAIL wr_we_n: got %b want 110011", cap_wen[5:0]);
    else n_pass++;
    n_total++;
    if (cap_oe[5:0] !== 6'b011110)
      $display("FAIL wr_oe: got %b want 011110", cap_oe[5:0]);
    else n_pass++;
    n_total++;
    if (cap_aack[5:0] !== 6'b010000 || cap_back[5:0] !== '0)
      $display("FAIL wr_ack: a=%b b=%b want 010000 000000",
               cap_aack[5:0], cap_back[5:0]);
    else n_pass++;
    n_total++;
    if (sram_rd(19'h12345) !== 8'hA5)
      $display("FAIL wr_mem: got %h want a5", sram_rd(19'h12345));
    else n_pass++;
    ref_mem[int'(19'h12345)] = 8'hA5;
    last_b = 1'b0;
  endtask

  task automatic test_single_read_b();
    sram_mem[int'(19'h7FFFF)] = 8'h3C;
    ref_mem[int'(19'h7FFFF)]  = 8'h3C;
    tick();
    b_req = 1'b1; b_we = 1'b0; b_addr = 19'h7FFFF;
    capture(6, 0, 1);
    exp_brd = ref_rd(19'h7FFFF);
    n_total++;
    if (cap_back[5:0] !== 6'b010000 || cap_aack[5:0] !== '0)
      $display("FAIL rd_ack: b=%b a=%b want 010000 000000",
               cap_back[5:0], cap_aack[5:0]);
    else n_pass++;
    n_total++;
    if (cap_brd[4] !== exp_brd || b_rdata !== exp_brd)
      $display("FAIL rd_data: ack=%h held=%h want %h",
               cap_brd[4], b_rdata, exp_brd);
    else n_pass++;
    n_total++;
    if (cap_oe[5:0] !== '0 || cap_wen[5:0] !== 6'b111111)
      $display("FAIL rd_bus: oe=%b we_n=%b want 000000 111111",
               cap_oe[5:0], cap_wen[5:0]);
    else n_pass++;
    n_total++;
    if (a_rdata !== exp_ard)
      $display("FAIL rd_a_untouched: got %h want %h", a_rdata, exp_ard);
    else n_pass++;
    last_b = 1'b1;
  endtask

  task automatic test_contention();
    logic [63:0] ea, eb, ewen;
    int          per, g;
    bit          is_b;
    per = 3 + WS;
    ea = '0; eb = '0; ewen = '0;
    for (int c = 0; c < 21; c++) ewen[c] = 1'b1;
    is_b = !last_b;
    for (int k = 0; k < 4; k++) begin
      g = k * per;
      if (is_b) begin
        eb[g+2+WS] = 1'b1;
        for (int s = 0; s < WS; s++) ewen[g+2+s] = 1'b0;
      end else begin
        ea[g+2+WS] = 1'b1;
      end
      is_b = !is_b;
    end
    tick();
    a_req = 1'b1; a_we = 1'b0; a_addr = 19'h00010;
    b_req = 1'b1; b_we = 1'b1; b_addr = 19'h00020; b_wdata = 8'hC3;
    capture(21, 2, 2);
    ref_mem[int'(19'h00020)] = 8'hC3;
    exp_ard = ref_rd(19'h00010);
    n_total++;
    if (cap_aack !== ea)
      $display("FAIL cont_a_ack: got %h want %h", cap_aack, ea);
    else n_pass++;
    n_total++;
    if (cap_back !== eb)
      $display("FAIL cont_b_ack: got %h want %h", cap_back, eb);
    else n_pass++;
    n_total++;
    if (cap_wen !== ewen)
      $display("FAIL cont_we_n: got %h want %h", cap_wen, ewen);
    else n_pass++;
    n_total++;
    if (a_rdata !== exp_ard || sram_rd(19'h00020) !== 8'hC3)
      $display("FAIL cont_data: ard=%h want %h mem=%h want c3",
               a_rdata, exp_ard, sram_rd(19'h00020));
    else n_pass++;
    last_b = is_b ? 1'b0 : 1'b1;
    last_b = !is_b;
  endtask

  task automatic test_early_drop();
    tick();
    a_req = 1'b1; a_we = 1'b1; a_addr = 19'h00200; a_wdata = 8'h5E;
    tick();
    a_req = 1'b0; a_addr = 19'h00300; a_wdata = 8'hFF;
    capture(5, 99, 99);
    n_total++;
    if (cap_aack[4:0] !== 5'b01000)
      $display("FAIL drop_ack: got %b want 01000", cap_aack[4:0]);
    else n_pass++;
    n_total++;
    if (cap_addr[0] !== 19'h00200 || cap_addr[3] !== 19'h00200)
      $display("FAIL drop_addr: got %h/%h want 00200",
               cap_addr[0], cap_addr[3]);
    else n_pass++;
    n_total++;
    if (sram_rd(19'h00200) !== 8'h5E || sram_mem.exists(int'(19'h00300)))
      $display("FAIL drop_mem: got %h want 5e", sram_rd(19'h00200));
    else n_pass++;
    ref_mem[int'(19'h00200)] = 8'h5E;
    last_b = 1'b0;
  endtask

  task automatic test_random();
    int          mode, nc;
    bit          first_b, has_a, has_b;
    logic [63:0] ea, eb;
    int          nwr, nlow;
    for (int it = 0; it < 60; it++) begin
      mode  = $urandom_range(1, 3);
      has_a = mode[0];
      has_b = mode[1];
      a_we = 1'($urandom_range(0, 1));
      b_we = 1'($urandom_range(0, 1));
      a_addr = AW'($urandom_range(0, 7));
      b_addr = AW'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) a_addr = a_addr | 19'h7FFF8;
      if ($urandom_range(0, 3) == 0) b_addr = b_addr | 19'h7FFF8;
      a_wdata = 8'($urandom);
      b_wdata = 8'($urandom);
      first_b = (has_a && has_b) ? !last_b : has_b;
      ea = '0; eb = '0; nwr = 0;
      for (int k = 0; k < 2; k++) begin
        bit pb;
        pb = (k == 0) ? first_b : !first_b;
        if (k == 0 || (has_a && has_b)) begin
          if (pb) begin
            eb[k*(3+WS)+2+WS] = 1'b1;
            if (b_we) begin ref_mem[int'(b_addr)] = b_wdata; nwr++; end
            else exp_brd = ref_rd(b_addr);
          end else begin
            ea[k*(3+WS)+2+WS] = 1'b1;
            if (a_we) begin ref_mem[int'(a_addr)] = a_wdata; nwr++; end
            else exp_ard = ref_rd(a_addr);
          end
          last_b = pb;
        end
      end
      nc = (has_a && has_b) ? 11 : 6;
      tick();
      a_req = has_a;
      b_req = has_b;
      capture(nc, has_a ? 1 : 0, has_b ? 1 : 0);
      nlow = 0;
      for (int c = 0; c < nc; c++) if (!cap_wen[c]) nlow++;
      n_total++;
      if (cap_aack !== ea || cap_back !== eb)
        $display("FAIL rnd_ack it%0d: a=%h b=%h want %h %h",
                 it, cap_aack, cap_back, ea, eb);
      else n_pass++;
      n_total++;
      if (a_rdata !== exp_ard || b_rdata !== exp_brd)
        $display("FAIL rnd_rdata it%0d: a=%h b=%h want %h %h",
                 it, a_rdata, b_rdata, exp_ard, exp_brd);
      else n_pass++;
      n_total++;
      if (nlow != nwr * WS)
        $display("FAIL rnd_strobe it%0d: got %0d want %0d",
                 it, nlow, nwr * WS);
      else n_pass++;
      n_total++;
      if ((has_a && a_we && sram_rd(a_addr) !== ref_rd(a_addr)) ||
          (has_b && b_we && sram_rd(b_addr) !== ref_rd(b_addr)))
        $display("FAIL rnd_mem it%0d: a=%h/%h b=%h/%h", it,
                 sram_rd(a_addr), ref_rd(a_addr),
                 sram_rd(b_addr), ref_rd(b_addr));
      else n_pass++;
    end
  endtask

  task automatic test_wait_states();
    int lat1, lat15, low1, low15;
    lat1 = -1; lat15 = -1; low1 = 0; low15 = 0;
    tick();
    r1_req  = 1'b1;
    r15_req = 1'b1;
    for (int c = 0; c < 22; c++) begin
      bit d1, d15;
      @(negedge clk);
      if (!x1_wen) low1++;
      if (!x15_wen) low15++;
      d1  = x1_aack && lat1 < 0;
      d15 = x15_aack && lat15 < 0;
      if (d1) lat1 = c;
      if (d15) lat15 = c;
      if (d1 || d15) begin
        tick();
        if (d1) r1_req = 1'b0;
        if (d15) r15_req = 1'b0;
      end
    end
    n_total++;
    if (lat1 != 3 || low1 != 1)
      $display("FAIL ws1: latency=%0d low=%0d want 3 1", lat1, low1);
    else n_pass++;
    n_total++;
    if (lat15 != 17 || low15 != 15)
      $display("FAIL ws15: latency=%0d low=%0d want 17 15", lat15, low15);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_single_read_b();
    test_contention();
    test_early_drop();
    test_random();
    test_wait_states();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
